freq_bcd_display: RTL and testbench

- Downstream consumer of the frequency meter's binary count output.
- Each time a new count is presented with a valid strobe, converts it to packed BCD with a sequential double-dabble.
- Latches the result and drives a time-multiplexed, active-low 7-segment display.
- Also exposes the BCD word for other consumers, such as a UART report stage.

---
 rtl/freq_pkg.sv | 29 ++
 rtl/freq_bcd_display_seg7_scan.sv | 82 ++++++++
 rtl/freq_bcd_display.sv | 129 ++++++++++++
 tb/tb_freq_bcd_display.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared definitions for the frequency display slice.
//   SEG_DASH / SEG_BLANK : active-low segment patterns {dp,g,f,e,d,c,b,a}
//   SEG_TABLE            : decimal digit 0-9 to active-low segment pattern
//   state_t              : conversion FSM states
//   pow10()              : 10^n, used for the overflow threshold
package freq_pkg;

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG_TABLE [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/freq_bcd_display_seg7_scan.sv
// Time-multiplexed active-low 7-segment driver.
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture bcd_in/dash_in into the display register
//   bcd_in   : packed BCD digits, digit 0 in bits [3:0]
//   dash_in  : show '-' on every digit instead of the BCD value
//   seg      : registered active-low segments {dp,g,f,e,d,c,b,a}
//   an       : registered active-low one-hot digit enable
module seg7_scan
  import freq_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000,
  parameter int LZ_BLANK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  dash_in,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] disp;
  logic                dash;
  logic [CW-1:0]       sc_cnt;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_n;
  logic                wrap;
  logic [3:0]          nib;
  logic                zero_above;
  logic [7:0]          seg_n;

  assign wrap = (sc_cnt == CW'(SCAN_DIV - 1));

  always_comb begin
    idx_n = idx;
    if (wrap) idx_n = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
  end

  // Segment pattern for the slot being selected at this edge, so that
  // an and seg always move together.
  always_comb begin
    nib        = disp[4*idx_n +: 4];
    zero_above = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (i >= 32'(idx_n) && disp[4*i +: 4] != 4'd0) zero_above = 1'b0;
    end
    if (dash)
      seg_n = SEG_DASH;
    else if (LZ_BLANK != 0 && idx_n != '0 && zero_above)
      seg_n = SEG_BLANK;
    else if (nib < 4'd10)
      seg_n = SEG_TABLE[nib];
    else
      seg_n = SEG_BLANK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp   <= '0;
      dash   <= 1'b0;
      sc_cnt <= '0;
      idx    <= '0;
      seg    <= SEG_TABLE[0];
      an     <= ~DIGITS'(1);
    end else begin
      sc_cnt <= wrap ? '0 : sc_cnt + CW'(1);
      idx    <= idx_n;
      an     <= ~(DIGITS'(1) << idx_n);
      seg    <= seg_n;
      if (load) begin
        disp <= bcd_in;
        dash <= dash_in;
      end
    end
  end

endmodule

// File: rtl/freq_bcd_display.sv
// Binary frequency count to packed BCD with a multiplexed 7-segment display.
//   Clk, Rst  : clock, asynchronous active-high reset
//   FreqBin   : binary count, sampled while FreqValid is high
//   FreqValid : one-cycle request strobe
//   Busy      : conversion running or a request pending
//   BcdOut    : packed BCD result (all 4'hF on overflow)
//   BcdValid  : one-cycle pulse when BcdOut/Overflow update
//   Overflow  : last captured count was >= 10^DIGITS
//   SegOut    : active-low segments {dp,g,f,e,d,c,b,a}
//   AnOut     : active-low one-hot digit enable
module freq_bcd_display
  import freq_pkg::*;
#(
  parameter int BIN_W    = 27,
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000,
  parameter int LZ_BLANK = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [BIN_W-1:0]      FreqBin,
  input  logic                  FreqValid,
  output logic                  Busy,
  output logic [4*DIGITS-1:0]   BcdOut,
  output logic                  BcdValid,
  output logic                  Overflow,
  output logic [7:0]            SegOut,
  output logic [DIGITS-1:0]     AnOut
);

  localparam int              BW    = 4 * DIGITS;
  localparam int              CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W:0]  LIMIT = (BIN_W + 1)'(pow10(DIGITS));

  state_t             state;
  logic [BIN_W-1:0]   shreg;
  logic [BIN_W-1:0]   pend_val;
  logic               pending;
  logic [BW-1:0]      bcd;
  logic [BW-1:0]      bcd_adj;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_cap;
  logic [BIN_W-1:0]   start_val;
  logic               disp_load;
  logic [BW-1:0]      result;

  // Double-dabble correction applied before each shift.
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // In DONE a strobe arriving that very cycle is newer than the pending one.
  assign start_val = FreqValid ? FreqBin : pend_val;
  assign result    = ovf_cap ? '1 : bcd;
  assign disp_load = (state == DONE);
  assign Busy      = (state != IDLE) || pending;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= IDLE;
      shreg    <= '0;
      pend_val <= '0;
      pending  <= 1'b0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_cap  <= 1'b0;
      BcdOut   <= '0;
      BcdValid <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      BcdValid <= 1'b0;
      case (state)
        IDLE: begin
          if (FreqValid) begin
            shreg   <= FreqBin;
            bcd     <= '0;
            cnt     <= '0;
            ovf_cap <= ({1'b0, FreqBin} >= LIMIT);
            state   <= CONV;
          end
        end
        CONV: begin
          bcd   <= {bcd_adj[BW-2:0], shreg[BIN_W-1]};
          shreg <= {shreg[BIN_W-2:0], 1'b0};
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BIN_W - 1)) state <= DONE;
          if (FreqValid) begin
            pend_val <= FreqBin;
            pending  <= 1'b1;
          end
        end
        DONE: begin
          BcdOut   <= result;
          BcdValid <= 1'b1;
          Overflow <= ovf_cap;
          if (FreqValid || pending) begin
            shreg   <= start_val;
            bcd     <= '0;
            cnt     <= '0;
            ovf_cap <= ({1'b0, start_val} >= LIMIT);
            pending <= 1'b0;
            state   <= CONV;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  seg7_scan #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .LZ_BLANK (LZ_BLANK)
  ) u_scan (
    .clk     (Clk),
    .rst     (Rst),
    .load    (disp_load),
    .bcd_in  (result),
    .dash_in (ovf_cap),
    .seg     (SegOut),
    .an      (AnOut)
  );

endmodule

// File: tb/tb_freq_bcd_display.sv
module tb_freq_bcd_display;

  localparam int     BIN_W = 27;
  localparam int     DIG   = 8;
  localparam int     LAT   = BIN_W + 1;
  localparam longint LIM   = 100000000;

  logic              Clk = 1'b0;
  logic              Rst = 1'b0;
  logic [BIN_W-1:0]  FreqBin = '0;
  logic              FreqValid = 1'b0;
  logic              Busy;
  logic [4*DIG-1:0]  BcdOut;
  logic              BcdValid;
  logic              Overflow;
  logic [7:0]        SegOut;
  logic [DIG-1:0]    AnOut;

  int checks   = 0;
  int failures = 0;

  freq_bcd_display #(
    .BIN_W    (BIN_W),
    .DIGITS   (DIG),
    .SCAN_DIV (4),
    .LZ_BLANK (1)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .FreqBin   (FreqBin),
    .FreqValid (FreqValid),
    .Busy      (Busy),
    .BcdOut    (BcdOut),
    .BcdValid  (BcdValid),
    .Overflow  (Overflow),
    .SegOut    (SegOut),
    .AnOut     (AnOut)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: decimal digits by arithmetic, all-F when out of range.
  function automatic logic [31:0] model_bcd(input longint v);
    logic [31:0] r;
    longint      t;
    if (v >= LIM) return '1;
    r = '0;
    t = v;
    for (int d = 0; d < DIG; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] digit_seg(input longint d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  default: return 8'h90;
    endcase
  endfunction

  function automatic logic [7:0] model_seg(input longint v, input int k);
    longint p;
    if (v >= LIM) return 8'hBF;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (k > 0 && v < p) return 8'hFF;
    return digit_seg((v / p) % 10);
  endfunction

  // Issue one request from idle and wait for the result pulse.
  task automatic convert(input longint v, input string nm);
    int lat;
    @(negedge Clk);
    FreqBin   = BIN_W'(v);
    FreqValid = 1'b1;
    @(posedge Clk);
    #1;
    FreqValid = 1'b0;
    FreqBin   = BIN_W'($urandom);
    chk({nm, "_busy"}, 64'(Busy), 64'd1);
    lat = -1;
    for (int k = 1; k <= LAT + 12; k++) begin
      @(posedge Clk);
      #1;
      if (BcdValid) begin
        lat = k;
        break;
      end
    end
    chk({nm, "_latency"}, 64'(lat), 64'(LAT));
    chk({nm, "_bcd"}, 64'(BcdOut), 64'(model_bcd(v)));
    chk({nm, "_ovf"}, 64'(Overflow), 64'(v >= LIM));
    @(posedge Clk);
    #1;
    chk({nm, "_pulse_width"}, 64'(BcdValid), 64'd0);
  endtask

  // Watch the scan for a while: one-hot anode, correct order, 4-cycle slots,
  // and the segment pattern expected for the value on each slot.
  task automatic check_scan(input longint v, input string nm);
    int  prev = -1;
    int  run  = 0;
    bit  first = 1'b1;
    int  k;
    for (int n = 0; n < 36; n++) begin
      @(negedge Clk);
      k = -1;
      for (int j = 0; j < DIG; j++) if (AnOut == ~(DIG'(1) << j)) k = j;
      if (k < 0) begin
        checks++;
        failures++;
        $display("FAIL %s_an_onehot: got %0h expected a single low bit", nm, AnOut);
      end else begin
        chk({nm, "_seg"}, 64'(SegOut), 64'(model_seg(v, k)));
        if (prev >= 0 && k != prev) begin
          chk({nm, "_an_order"}, 64'(k), 64'((prev + 1) % DIG));
          if (!first) chk({nm, "_slot_len"}, 64'(run), 64'd4);
          first = 1'b0;
          run   = 0;
        end
        run++;
        prev = k;
      end
    end
  endtask

  typedef struct {
    longint      bin;
    logic [31:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int nvalid;
    int busy_bad;
    int bad_pulse;
    logic busy56;

    vecs[0] = '{12345678,  32'h12345678, 1'b0};
    vecs[1] = '{0,         32'h00000000, 1'b0};
    vecs[2] = '{100000000, 32'hFFFFFFFF, 1'b1};
    vecs[3] = '{9,         32'h00000009, 1'b0};
    vecs[4] = '{99999999,  32'h99999999, 1'b0};
    vecs[5] = '{134217727, 32'hFFFFFFFF, 1'b1};
    vecs[6] = '{10000000,  32'h10000000, 1'b0};
    vecs[7] = '{100000,    32'h00100000, 1'b0};

    // Reset state
    @(negedge Clk);
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_bcd", 64'(BcdOut), 64'd0);
    chk("rst_valid", 64'(BcdValid), 64'd0);
    chk("rst_ovf", 64'(Overflow), 64'd0);
    chk("rst_seg", 64'(SegOut), 64'hC0);
    chk("rst_an", 64'(AnOut), 64'hFE);
    Rst = 1'b0;

    // Directed vectors, including display scan
    for (int i = 0; i < 8; i++) begin
      convert(vecs[i].bin, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_table_bcd", i), 64'(BcdOut), 64'(vecs[i].bcd));
      chk($sformatf("vec%0d_table_ovf", i), 64'(Overflow), 64'(vecs[i].ovf));
      check_scan(vecs[i].bin, $sformatf("vec%0d_scan", i));
    end

    // Pending requests: 5 at edge 0, 77 at edge 10, 88 at edge 12
    nvalid   = 0;
    busy_bad = 0;
    busy56   = 1'b1;
    for (int e = 0; e <= 60; e++) begin
      @(negedge Clk);
      FreqValid = (e == 0 || e == 10 || e == 12);
      FreqBin   = (e == 0) ? 27'd5 : (e == 10) ? 27'd77 : (e == 12) ? 27'd88
                                   : BIN_W'($urandom);
      @(posedge Clk);
      #1;
      if (BcdValid) begin
        nvalid++;
        if (nvalid == 1) begin
          chk("pend_first_edge", 64'(e), 64'(LAT));
          chk("pend_first_bcd", 64'(BcdOut), 64'h5);
        end else begin
          chk("pend_second_edge", 64'(e), 64'(2 * LAT));
          chk("pend_second_bcd", 64'(BcdOut), 64'h88);
        end
      end
      if (e <= 2 * LAT - 1 && !Busy) busy_bad++;
      if (e == 2 * LAT) busy56 = Busy;
    end
    FreqValid = 1'b0;
    chk("pend_valid_count", 64'(nvalid), 64'd2);
    chk("pend_busy_held", 64'(busy_bad), 64'd0);
    chk("pend_busy_released", 64'(busy56), 64'd0);

    // Reset in the middle of a conversion of 999
    @(negedge Clk);
    FreqBin   = 27'd999;
    FreqValid = 1'b1;
    @(posedge Clk);
    #1;
    FreqValid = 1'b0;
    repeat (14) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(Busy), 64'd0);
    chk("midrst_bcd", 64'(BcdOut), 64'd0);
    chk("midrst_valid", 64'(BcdValid), 64'd0);
    chk("midrst_ovf", 64'(Overflow), 64'd0);
    chk("midrst_seg", 64'(SegOut), 64'hC0);
    chk("midrst_an", 64'(AnOut), 64'hFE);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    bad_pulse = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (BcdValid) bad_pulse++;
    end
    chk("midrst_no_pulse", 64'(bad_pulse), 64'd0);
    convert(999, "after_rst");

    // Randomized values against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      longint v;
      case ($urandom_range(0, 3))
        0:       v = longint'($urandom_range(0, 134217727));
        1:       v = longint'($urandom_range(0, 999));
        2:       v = longint'($urandom_range(99999990, 100000010));
        default: v = longint'($urandom_range(0, 99999999));
      endcase
      convert(v, $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
